// File: rtl/individual_fitness_acc.sv
// rtl/individual_fitness_acc.sv - Hamming-distance fitness accumulator for one 4x16-bit individual
//
// Scores one evolved individual against golden outputs over NUM_VECTORS accepted vectors.
// Each accepted vector contributes popcount({y3..y0} ^ {e3..e0}) (0..64) to a saturating
// score. The popcount is registered first, then accumulated, so the individual's
// combinational logic feeding y*/e* does not share a cycle with the adder.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a new run (taken only in IDLE or DONE)
//   in_valid   in   1      vector present on y*/e*
//   in_ready   out  1      vector accepted this cycle if in_valid
//   y3..y0     in   16 ea  individual outputs
//   e3..e0     in   16 ea  golden outputs
//   score      out  FIT_W  accumulated Hamming distance, 0 = perfect
//   vec_count  out  16     vectors accepted in current run
//   busy       out  1      run in progress (RUN or DRAIN)
//   done       out  1      result valid, held until next start
//   perfect    out  1      done with zero distance
//   saturated  out  1      score clipped at its maximum during this run

module individual_fitness_acc #(
  parameter int NUM_VECTORS = 16,
  parameter int FIT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  input  logic [15:0]      e3,
  input  logic [15:0]      e2,
  input  logic [15:0]      e1,
  input  logic [15:0]      e0,
  output logic [FIT_W-1:0] score,
  output logic [15:0]      vec_count,
  output logic             busy,
  output logic             done,
  output logic             perfect,
  output logic             saturated
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0]      NV        = 16'(NUM_VECTORS);
  localparam logic [FIT_W-1:0] SCORE_MAX = '1;

  state_t           state;
  state_t           state_nx;

  logic             valid1;     // popcount stage holds a vector
  logic [6:0]       d1;         // its distance, 0..64
  logic             valid2;     // accumulate stage consumed a vector last edge
  logic             accept;
  logic             start_ok;
  logic [FIT_W:0]   sum;        // one extra bit to detect overflow

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Ready depends only on registered state so there is no path from in_valid to in_ready.
  assign in_ready  = (state == S_RUN) && (vec_count < NV);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign sum       = {1'b0, score} + (FIT_W+1)'(d1);

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign perfect   = done && (score == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (vec_count == NV) state_nx = S_DRAIN;
      // Wait until the final vector has left both pipeline stages.
      S_DRAIN: if (!valid1 && !valid2) state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1    <= 1'b0;
      d1        <= '0;
      valid2    <= 1'b0;
      score     <= '0;
      vec_count <= '0;
      saturated <= 1'b0;
    end else begin
      valid1 <= accept;
      valid2 <= valid1;
      if (accept) begin
        d1 <= popcount64({y3, y2, y1, y0} ^ {e3, e2, e1, e0});
      end

      // Both pipeline stages are empty in IDLE/DONE, so a start never collides
      // with an accumulate.
      if (start_ok) begin
        score     <= '0;
        vec_count <= '0;
        saturated <= 1'b0;
      end else begin
        if (accept) begin
          vec_count <= vec_count + 16'd1;
        end
        if (valid1) begin
          if (sum[FIT_W]) begin
            score     <= SCORE_MAX;
            saturated <= 1'b1;
          end else begin
            score <= sum[FIT_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_individual_fitness_acc.sv
// tb/tb_individual_fitness_acc.sv - directed self-checking bench for individual_fitness_acc

module tb_individual_fitness_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic        in_valid;
  logic [63:0] ybus;
  logic [63:0] ebus;

  logic        in_ready;
  logic [15:0] score;
  logic [15:0] vec_count;
  logic        busy, done, perfect, saturated;

  logic        in_ready2;
  logic [6:0]  score2;
  logic [15:0] vec_count2;
  logic        busy2, done2, perfect2, saturated2;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int exp_sum;

  individual_fitness_acc #(.NUM_VECTORS(16), .FIT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .y3(ybus[63:48]), .y2(ybus[47:32]), .y1(ybus[31:16]), .y0(ybus[15:0]),
    .e3(ebus[63:48]), .e2(ebus[47:32]), .e1(ebus[31:16]), .e0(ebus[15:0]),
    .score(score), .vec_count(vec_count), .busy(busy), .done(done),
    .perfect(perfect), .saturated(saturated)
  );

  individual_fitness_acc #(.NUM_VECTORS(3), .FIT_W(7)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .y3(ybus[63:48]), .y2(ybus[47:32]), .y1(ybus[31:16]), .y0(ybus[15:0]),
    .e3(ebus[63:48]), .e2(ebus[47:32]), .e1(ebus[31:16]), .e0(ebus[15:0]),
    .score(score2), .vec_count(vec_count2), .busy(busy2), .done(done2),
    .perfect(perfect2), .saturated(saturated2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // in_ready must only be seen while running (busy and not done).
  always @(negedge clk) begin
    if (rst_n && in_ready && (done || !busy)) viol++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Presents one vector and returns just after the edge that accepted it.
  task automatic send(input logic [63:0] yv, input logic [63:0] ev);
    int n;
    in_valid = 1'b1;
    ybus     = yv;
    ebus     = ev;
    n = 0;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    tick;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick;
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    ybus = '0; ebus = '0;
    tick; tick;
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_vcnt", {16'd0, vec_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: perfect match, back-to-back, done timing; in_valid held through DRAIN/DONE
    do_start;
    for (int i = 0; i < 16; i++) begin
      send({16'(i * 3 + 1), 16'h5A5A, 16'(i), 16'hBEEF}, {16'(i * 3 + 1), 16'h5A5A, 16'(i), 16'hBEEF});
    end
    chk("t1_ready_drop", {31'd0, in_ready}, 32'd0);
    tick;
    chk("t1_done_e1", {31'd0, done}, 32'd0);
    tick;
    chk("t1_done_e2", {31'd0, done}, 32'd0);
    tick;
    chk("t1_done_e3", {31'd0, done}, 32'd1);
    chk("t1_perfect", {31'd0, perfect}, 32'd1);
    chk("t1_score", {16'd0, score}, 32'd0);
    tick; tick;
    chk("t1_vcnt", {16'd0, vec_count}, 32'd16);
    in_valid = 1'b0;

    // 2: one bit in vector 0, sixteen bits in vector 1
    do_start;
    send(64'h0000_0000_0000_0001, 64'd0);
    send(64'hFFFF_0000_0000_0000, 64'd0);
    for (int i = 2; i < 16; i++) send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    in_valid = 1'b0;
    wait_done("t2_done");
    chk("t2_score", {16'd0, score}, 32'd17);
    chk("t2_perfect", {31'd0, perfect}, 32'd0);

    // 3: random gaps and data
    exp_sum = 0;
    viol = 0;
    do_start;
    for (int i = 0; i < 16; i++) begin
      logic [63:0] yr, er;
      in_valid = 1'b0;
      while ($urandom_range(1, 0) == 1) tick;
      yr = {$urandom, $urandom};
      er = {$urandom, $urandom};
      exp_sum += $countones(yr ^ er);
      send(yr, er);
    end
    in_valid = 1'b0;
    wait_done("t3_done");
    chk("t3_score", {16'd0, score}, 32'(exp_sum));
    chk("t3_vcnt", {16'd0, vec_count}, 32'd16);
    chk("t3_ready_outside_run", 32'(viol), 32'd0);

    // 4: FIT_W=7 instance, every bit differs (d=64); dut stays in DONE meanwhile
    in_valid = 1'b1;
    ybus = '1;
    ebus = '0;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    tick; tick;
    chk("t4_score_v1", {25'd0, score2}, 32'd64);
    tick;
    chk("t4_score_v2", {25'd0, score2}, 32'd127);
    chk("t4_sat_v2", {31'd0, saturated2}, 32'd1);
    for (int n = 0; n < 20 && !done2; n++) tick;
    chk("t4_done", {31'd0, done2}, 32'd1);
    chk("t4_score_end", {25'd0, score2}, 32'd127);
    chk("t4_sat_end", {31'd0, saturated2}, 32'd1);
    chk("t4_vcnt", {16'd0, vec_count2}, 32'd3);
    chk("t4_idle_dut_vcnt", {16'd0, vec_count}, 32'd16);
    chk("t4_idle_dut_done", {31'd0, done}, 32'd1);
    in_valid = 1'b0;

    // 5: asynchronous reset after 5 accepts (16 bits per vector)
    do_start;
    for (int i = 0; i < 5; i++) send(64'h000F_000F_000F_000F, 64'd0);
    in_valid = 1'b0;
    chk("t5_pre_score", {16'd0, score}, 32'd64);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_score", {16'd0, score}, 32'd0);
    chk("t5_vcnt", {16'd0, vec_count}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t5_idle", {31'd0, busy}, 32'd0);
    do_start;
    for (int i = 0; i < 16; i++) send(64'h000F_000F_000F_000F, 64'd0);
    in_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_rerun_score", {16'd0, score}, 32'd256);
    chk("t5_rerun_vcnt", {16'd0, vec_count}, 32'd16);

    // 6: start ignored in RUN; start in DONE with in_valid high
    do_start;
    for (int i = 0; i < 3; i++) send(64'h000F_000F_000F_000F, 64'd0);
    in_valid = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t6_run_start_vcnt", {16'd0, vec_count}, 32'd3);
    chk("t6_run_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 3; i < 16; i++) send(64'h000F_000F_000F_000F, 64'd0);
    in_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_score", {16'd0, score}, 32'd256);
    in_valid = 1'b1;
    ybus = 64'h000F_000F_000F_000F;
    ebus = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t6_clr_score", {16'd0, score}, 32'd0);
    chk("t6_clr_vcnt", {16'd0, vec_count}, 32'd0);
    chk("t6_clr_sat", {31'd0, saturated}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_done_low", {31'd0, done}, 32'd0);
    tick;
    chk("t6_first_accept", {16'd0, vec_count}, 32'd1);
    for (int i = 1; i < 16; i++) send(64'h000F_000F_000F_000F, 64'd0);
    in_valid = 1'b0;
    wait_done("t6_done2");
    chk("t6_score2", {16'd0, score}, 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
